pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 140 ++++++++++++++
 tb/tb_pipe_adder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// pipe_adder: N-bit signed add/subtract split into STAGES carry-chained slices, valid/ready flow control.
// Build option: define PIPE_ADDER_SAT_EN to saturate S on signed overflow.
module pipe_adder #(
    parameter int N      = 16,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         ci,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         co,
    output logic         ovf
);
    localparam int W   = N / STAGES;
    localparam int TOP = (STAGES - 1) * W;

    if (N < 2 || STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_adder: need N >= 2, 1 <= STAGES <= N and N divisible by STAGES");
    end

    // Stage k holds operands with slices below k already consumed (zeroed) and sum slices below k filled in.
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [N-1:0]      a_q [STAGES];
    logic [N-1:0]      a_d [STAGES];
    logic [N-1:0]      b_q [STAGES];
    logic [N-1:0]      b_d [STAGES];
    logic [N-1:0]      s_q [STAGES];
    logic [N-1:0]      s_d [STAGES];
    logic [W:0]        slc [STAGES];

    logic              out_valid_q, out_valid_d;
    logic [N-1:0]      res_q, res_d;
    logic              co_q, co_d;
    logic              ovf_q, ovf_d;

    logic              adv;
    logic [N-1:0]      s_raw;
    logic [N-1:0]      s_fin;
    logic              ovf_raw;
    logic              a_sign;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign S         = res_q;
    assign co        = co_q;
    assign ovf       = ovf_q;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            slc[k] = {1'b0, a_q[k][k*W +: W]} + {1'b0, b_q[k][k*W +: W]} + {{W{1'b0}}, c_q[k]};
        end
    end

    always_comb begin
        a_sign           = a_q[STAGES-1][N-1];
        s_raw            = s_q[STAGES-1];
        s_raw[TOP +: W]  = slc[STAGES-1][W-1:0];
        ovf_raw          = (a_sign == b_q[STAGES-1][N-1]) && (s_raw[N-1] != a_sign);
        s_fin            = s_raw;
`ifdef PIPE_ADDER_SAT_EN
        if (ovf_raw) begin
            s_fin = a_sign ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        vld_d       = vld_q;
        c_d         = c_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        co_d        = co_q;
        ovf_d       = ovf_q;
        if (adv) begin
            vld_d[0] = in_valid;
            if (in_valid) begin
                a_d[0] = A;
                b_d[0] = sub ? ~B : B;
                c_d[0] = sub | ci;
                s_d[0] = '0;
            end
            for (int k = 1; k < STAGES; k++) begin
                vld_d[k]                 = vld_q[k-1];
                c_d[k]                   = slc[k-1][W];
                a_d[k]                   = a_q[k-1];
                a_d[k][(k-1)*W +: W]     = '0;
                b_d[k]                   = b_q[k-1];
                b_d[k][(k-1)*W +: W]     = '0;
                s_d[k]                   = s_q[k-1];
                s_d[k][(k-1)*W +: W]     = slc[k-1][W-1:0];
            end
            out_valid_d = vld_q[STAGES-1];
            // Result registers keep their last value across bubbles.
            if (vld_q[STAGES-1]) begin
                res_d = s_fin;
                co_d  = slc[STAGES-1][W];
                ovf_d = ovf_raw;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q       <= '0;
            c_q         <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            res_q       <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            c_q         <= c_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            co_q        <= co_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed vectors and flow-control sequences for pipe_adder with N=8, STAGES=2.
module tb_pipe_adder;
    localparam int N      = 8;
    localparam int STAGES = 2;
`ifdef PIPE_ADDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         ci;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] S;
    logic         co;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    pipe_adder #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .co        (co),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       sub;
        logic [7:0] s_wrap;
        logic [7:0] s_sat;
        logic       co;
        logic       ovf;
    } vec_t;

    vec_t vecs[11];

    logic [7:0] bb_a  [4];
    logic [7:0] bb_b  [4];
    logic       bb_sub[4];
    logic [7:0] bb_s  [4];
    logic       bb_co [4];

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        lat = 0;
        @(negedge clk);
        A         = v.a;
        B         = v.b;
        ci        = v.ci;
        sub       = v.sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (lat == 0) begin
                @(posedge clk);
                #1;
                if (out_valid) lat = c;
            end
        end
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(STAGES));
        chk($sformatf("v%0d_S", idx), 32'(S), 32'(SAT ? v.s_sat : v.s_wrap));
        chk($sformatf("v%0d_co", idx), 32'(co), 32'(v.co));
        chk($sformatf("v%0d_ovf", idx), 32'(ovf), 32'(v.ovf));
    endtask

    initial begin
        //        a      b      ci    sub   s_wrap s_sat  co    ovf
        vecs[0]  = '{8'd100, 8'd27, 1'b0, 1'b0, 8'h7F, 8'h7F, 1'b0, 1'b0};
        vecs[1]  = '{8'd100, 8'd28, 1'b0, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1};
        vecs[2]  = '{8'h80,  8'h01, 1'b0, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b1};
        vecs[3]  = '{8'hFF,  8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{8'h0F,  8'h01, 1'b0, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0};
        vecs[5]  = '{8'h05,  8'h03, 1'b1, 1'b1, 8'h02, 8'h02, 1'b1, 1'b0};
        vecs[6]  = '{8'h03,  8'h05, 1'b0, 1'b1, 8'hFE, 8'hFE, 1'b0, 1'b0};
        vecs[7]  = '{8'h9C,  8'hE3, 1'b0, 1'b0, 8'h7F, 8'h80, 1'b1, 1'b1};
        vecs[8]  = '{8'h7F,  8'h7F, 1'b1, 1'b0, 8'hFF, 8'h7F, 1'b0, 1'b1};
        vecs[9]  = '{8'h00,  8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[10] = '{8'h55,  8'hAA, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};

        // 3+1, 19-2, 35+3, 51-4
        bb_a[0] = 8'd3;  bb_b[0] = 8'd1; bb_sub[0] = 1'b0; bb_s[0] = 8'd4;  bb_co[0] = 1'b0;
        bb_a[1] = 8'd19; bb_b[1] = 8'd2; bb_sub[1] = 1'b1; bb_s[1] = 8'd17; bb_co[1] = 1'b1;
        bb_a[2] = 8'd35; bb_b[2] = 8'd3; bb_sub[2] = 1'b0; bb_s[2] = 8'd38; bb_co[2] = 1'b0;
        bb_a[3] = 8'd51; bb_b[3] = 8'd4; bb_sub[3] = 1'b1; bb_s[3] = 8'd47; bb_co[3] = 1'b1;

        rst       = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        ci        = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;

        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_co", 32'(co), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Back-to-back stream with the first result stalled for three cycles.
        @(negedge clk);
        out_ready = 1'b1;
        fork
            begin : drv
                int  n;
                int  guard;
                logic acc;
                n = 0;
                guard = 0;
                while (n < 4 && guard < 40) begin
                    @(negedge clk);
                    A        = bb_a[n];
                    B        = bb_b[n];
                    sub      = bb_sub[n];
                    ci       = 1'b0;
                    in_valid = 1'b1;
                    #1;
                    acc = in_ready;
                    @(posedge clk);
                    if (acc) n++;
                    guard++;
                end
                @(negedge clk);
                in_valid = 1'b0;
                chk("bb_accepted", 32'(n), 32'd4);
            end
            begin : mon
                int got;
                int stall;
                int cyc;
                got = 0;
                stall = 3;
                cyc = 0;
                while (got < 4 && cyc < 60) begin
                    @(negedge clk);
                    cyc++;
                    if (out_valid) begin
                        if (got == 0 && stall > 0) begin
                            out_ready = 1'b0;
                            stall--;
                            #1;
                            chk($sformatf("bb_stall%0d_in_ready", 3 - stall), 32'(in_ready), 32'd0);
                            chk($sformatf("bb_stall%0d_S", 3 - stall), 32'(S), 32'(bb_s[0]));
                            chk($sformatf("bb_stall%0d_co", 3 - stall), 32'(co), 32'(bb_co[0]));
                        end else begin
                            out_ready = 1'b1;
                            chk($sformatf("bb_res%0d_S", got), 32'(S), 32'(bb_s[got]));
                            chk($sformatf("bb_res%0d_co", got), 32'(co), 32'(bb_co[got]));
                            chk($sformatf("bb_res%0d_ovf", got), 32'(ovf), 32'd0);
                            got++;
                        end
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                chk("bb_delivered", 32'(got), 32'd4);
                chk("bb_stalls", 32'(stall), 32'd0);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk("bb_no_dup", 32'(out_valid), 32'd0);

        // Reset with two transactions in flight.
        @(negedge clk);
        out_ready = 1'b1;
        A         = 8'd10;
        B         = 8'd20;
        sub       = 1'b0;
        ci        = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        A         = 8'd7;
        B         = 8'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_S", 32'(S), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_release_in_ready", 32'(in_ready), 32'd1);
        begin
            int stale;
            stale = 0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk);
                #1;
                if (out_valid) stale++;
            end
            chk("mid_rst_no_stale", 32'(stale), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
